param_data_buffer: RTL and testbench
====================================

Name: param_data_buffer

Overview:
Parametrised circular byte buffer between the AHB-Lite slave and the USB RX/TX packet engines, replacing the fixed 64-byte endpoint buffer. The AHB side writes and reads 1..DATA_BYTES bytes per access (little-endian). The RX engine writes one byte per strobe, and the TX engine reads one byte per strobe. It adds wrap-around pointers, overflow/underflow detection, AHB lockout and registered read data.

Parameters:
DEPTH, 64, buffer capacity in bytes; power of 2, minimum 8.
DATA_BYTES, 4, AHB word width in bytes; 1, 2 or 4.
Derived (localparam): AW = $clog2(DEPTH); OW = AW+1.

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous reset, active-low
clear  in  1  synchronous flush (from protocol controller)
lock_db  in  1  blocks AHB-side accesses while high
store_tx_data  in  1  AHB write strobe
tx_data  in  8*DATA_BYTES  AHB write data, byte 0 = [7:0]
data_size  in  2  AHB byte count minus 1 (0..DATA_BYTES-1)
get_rx_data  in  1  AHB read strobe
rx_data  out  8*DATA_BYTES  AHB read data, registered
store_rx_packet_data  in  1  RX byte write strobe
rx_packet_data  in  8  RX byte
get_tx_packet_data  in  1  TX byte read strobe
tx_packet_data  out  8  TX byte, registered
buffer_occupancy  out  OW  bytes currently held, 0..DEPTH
lock_error  out  1  one-cycle pulse
overflow_error  out  1  one-cycle pulse
underflow_error  out  1  one-cycle pulse

Behaviour:
- Reset (n_rst low, async):
  - wr_ptr, rd_ptr and occupancy are 0.
  - rx_data, tx_packet_data and all error pulses are 0.
  - Storage contents are don't-care.
- Pointers:
  - wr_ptr and rd_ptr are AW bits; they advance mod DEPTH, and byte k of an access uses (ptr+k) mod DEPTH.
  - Occupancy is a separate OW-bit register; buffer_occupancy = that register (registered output).
- Byte count: n = data_size+1. data_size >= DATA_BYTES is clamped to DATA_BYTES.
- Write arbitration: per cycle, one write source is allowed.
  - store_tx_data wins; a simultaneous store_rx_packet_data is dropped and overflow_error pulses.
- Read arbitration: per cycle, one read source is allowed.
  - get_rx_data wins; a simultaneous get_tx_packet_data is dropped and underflow_error pulses.
- Checks use the pre-cycle occupancy (occ).
  - A write of w bytes is accepted if occ + w <= DEPTH. Otherwise the whole write is rejected, nothing is stored, and overflow_error pulses.
  - A read of r bytes is accepted if occ >= r. Otherwise it is rejected, the pointer and the read output hold, and underflow_error pulses.
  - A same-cycle write and read are both evaluated against occ. A write into a full buffer is rejected even when a read occurs that cycle.
- Occupancy update: occ_next = occ + w_acc - r_acc.
- Read latency is 1 cycle. The output register loads on the clock edge of an accepted strobe and is valid the following cycle.
  - rx_data: unused upper bytes are 0.
  - Both outputs hold their value until the next accepted read.
- Lock FSM (states OPEN, LOCKED): OPEN -> LOCKED when lock_db=1; LOCKED -> OPEN when lock_db=0. Transitions are evaluated each cycle.
  - In LOCKED, store_tx_data and get_rx_data are ignored and lock_error pulses for each such strobe.
  - RX and TX strobes operate normally in LOCKED.
  - lock_db is sampled combinationally: a strobe in the same cycle that lock_db rises is already blocked.
- clear has highest priority:
  - Next cycle, wr_ptr = rd_ptr = occupancy = 0.
  - All strobes in the clear cycle are ignored, with no error pulses.
  - rx_data and tx_packet_data hold; storage is untouched.
- Error pulses:
  - Each error output is a registered pulse, high for exactly one cycle per offending cycle.
  - Multiple errors may assert in the same cycle.

Optional Feature:
Macro DB_WATERMARK_EN.
- Defined: adds output peak_occupancy (OW bits), a registered high-water mark = max of buffer_occupancy since the last reset or clear. It is 0 on reset and clear, and it updates in the same cycle as occupancy.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Assert n_rst=0 mid-traffic. Required: occupancy, rx_data, tx_packet_data and all errors read 0 immediately (async), and stay 0 after release with no strobes.
2. store_tx_data, tx_data=0xDDCCBBAA, data_size=3, then 4 get_tx_packet_data strobes. Required: tx_packet_data = AA, BB, CC, DD, each valid the cycle after its strobe; occupancy goes 4, 3, 2, 1, 0.
3. RX writes 0x11..0x15, then get_rx_data with size=1. Required: rx_data = 0x00001211 and occupancy 3. Then get_rx_data with size=3. Required: underflow_error pulses once, occupancy stays 3 and rx_data stays 0x00001211.
4. Wrap-around (DEPTH=64):
   - 16 word stores give occupancy 64; a 17th store gives overflow_error and occupancy 64.
   - Read 8 bytes, then store 2 words 0xA3A2A1A0 and 0xA7A6A5A4. Required: occupancy 64.
   - Drain via TX. Required: the last 8 bytes are A0..A7 in order.
5. Set lock_db=1 with occupancy 4, then issue get_rx_data and store_tx_data. Required: lock_error pulses 1 cycle each and occupancy stays 4; a get_tx_packet_data still returns the next byte and occupancy becomes 3.
6. At occupancy 10, issue clear together with store_tx_data. Required: occupancy 0 next cycle with no error pulses. With DB_WATERMARK_EN defined, peak_occupancy goes from 10 to 0.

Source files
------------

// File: rtl/param_data_buffer_if.sv
`default_nettype none
// ============================================================================
// param_data_buffer_if
// Bus bundle for param_data_buffer: AHB-side word access, RX/TX byte
// strobes, occupancy and error pulses. peak_occupancy exists only when
// DB_WATERMARK_EN is defined.
// Revision: 1.0
// ============================================================================
interface param_data_buffer_if #(
    parameter int DEPTH      = 64,
    parameter int DATA_BYTES = 4
);
    localparam int OW = $clog2(DEPTH) + 1;

    logic                      clear;
    logic                      lock_db;
    logic                      store_tx_data;
    logic [8*DATA_BYTES-1:0]   tx_data;
    logic [1:0]                data_size;
    logic                      get_rx_data;
    logic [8*DATA_BYTES-1:0]   rx_data;
    logic                      store_rx_packet_data;
    logic [7:0]                rx_packet_data;
    logic                      get_tx_packet_data;
    logic [7:0]                tx_packet_data;
    logic [OW-1:0]             buffer_occupancy;
    logic                      lock_error;
    logic                      overflow_error;
    logic                      underflow_error;
`ifdef DB_WATERMARK_EN
    logic [OW-1:0]             peak_occupancy;
`endif

    modport slave (
        input  clear, lock_db, store_tx_data, tx_data, data_size, get_rx_data,
               store_rx_packet_data, rx_packet_data, get_tx_packet_data,
        output rx_data, tx_packet_data, buffer_occupancy,
               lock_error, overflow_error, underflow_error
`ifdef DB_WATERMARK_EN
        , output peak_occupancy
`endif
    );

    modport master (
        output clear, lock_db, store_tx_data, tx_data, data_size, get_rx_data,
               store_rx_packet_data, rx_packet_data, get_tx_packet_data,
        input  rx_data, tx_packet_data, buffer_occupancy,
               lock_error, overflow_error, underflow_error
`ifdef DB_WATERMARK_EN
        , input peak_occupancy
`endif
    );
endinterface
`default_nettype wire

// File: rtl/param_data_buffer.sv
`default_nettype none
// ============================================================================
// param_data_buffer
// Circular byte buffer between AHB slave (1..DATA_BYTES per access) and the
// USB RX/TX byte engines. Optional high-water mark: DB_WATERMARK_EN.
// Revision: 1.0
// ============================================================================
module param_data_buffer #(
    parameter int DEPTH      = 64,
    parameter int DATA_BYTES = 4
) (
    input  wire logic           clk,
    input  wire logic           n_rst,
    param_data_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int XW = OW + 1;
    localparam int DW = 8 * DATA_BYTES;
    localparam logic [XW-1:0] c_DEPTH = XW'(DEPTH);
    localparam logic [2:0]    c_MAX_N = 3'(DATA_BYTES);

    typedef enum logic [0:0] {
        S_OPEN   = 1'b0,
        S_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t   r_lock_state;
    lock_state_t   w_lock_next;
    logic          w_blocked;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [OW-1:0] r_occ;
    logic [DW-1:0] r_rx_data;
    logic [7:0]    r_tx_data;
    logic          r_lck_err;
    logic          r_ovf_err;
    logic          r_unf_err;

    logic [2:0]    w_n;
    logic          w_ahb_wr;
    logic          w_ahb_rd;
    logic          w_rx_wr;
    logic          w_tx_rd;
    logic [2:0]    w_wcnt;
    logic [2:0]    w_rcnt;
    logic          w_wr_ok;
    logic          w_rd_ok;
    logic          w_ovf;
    logic          w_unf;
    logic          w_lck;
    logic [XW-1:0] w_occ_sum;
    logic [OW-1:0] w_occ_next;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_rd_word;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_lock_state <= S_OPEN;
        end else begin
            r_lock_state <= w_lock_next;
        end
    end

    // lock_db blocks combinationally so the rising-edge cycle is already locked
    always_comb begin
        w_lock_next = r_lock_state;
        w_blocked   = bus.lock_db;
        case (r_lock_state)
            S_OPEN: begin
                if (bus.lock_db) w_lock_next = S_LOCKED;
            end
            S_LOCKED: begin
                w_blocked = 1'b1;
                if (!bus.lock_db) w_lock_next = S_OPEN;
            end
            default: w_lock_next = S_OPEN;
        endcase
    end

    always_comb begin
        w_n = ({1'b0, bus.data_size} >= c_MAX_N) ? c_MAX_N
                                                 : ({1'b0, bus.data_size} + 3'd1);
        w_ahb_wr = !bus.clear && bus.store_tx_data && !w_blocked;
        w_ahb_rd = !bus.clear && bus.get_rx_data   && !w_blocked;
        w_rx_wr  = !bus.clear && bus.store_rx_packet_data;
        w_tx_rd  = !bus.clear && bus.get_tx_packet_data;
        w_lck    = !bus.clear && w_blocked && (bus.store_tx_data || bus.get_rx_data);

        w_wcnt = w_ahb_wr ? w_n : {2'b00, w_rx_wr};
        w_rcnt = w_ahb_rd ? w_n : {2'b00, w_tx_rd};

        // Both directions judged against the pre-cycle occupancy
        w_wr_ok = (w_wcnt != 3'd0) && (({1'b0, r_occ} + XW'(w_wcnt)) <= c_DEPTH);
        w_rd_ok = (w_rcnt != 3'd0) && ({1'b0, r_occ} >= XW'(w_rcnt));

        w_ovf = (w_ahb_wr && w_rx_wr) || ((w_wcnt != 3'd0) && !w_wr_ok);
        w_unf = (w_ahb_rd && w_tx_rd) || ((w_rcnt != 3'd0) && !w_rd_ok);

        w_occ_sum  = {1'b0, r_occ}
                   + (w_wr_ok ? XW'(w_wcnt) : '0)
                   - (w_rd_ok ? XW'(w_rcnt) : '0);
        w_occ_next = w_occ_sum[OW-1:0];

        w_wdata = w_ahb_wr ? bus.tx_data : DW'(bus.rx_packet_data);
    end

    // Little-endian gather; bytes beyond the access size read as zero
    always_comb begin
        w_rd_word = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            if (3'(k) < w_rcnt) begin
                w_rd_word[8*k +: 8] = r_mem[r_rd_ptr + AW'(k)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            for (int k = 0; k < DATA_BYTES; k++) begin
                if (3'(k) < w_wcnt) begin
                    r_mem[r_wr_ptr + AW'(k)] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_occ     <= '0;
            r_rx_data <= '0;
            r_tx_data <= '0;
            r_lck_err <= 1'b0;
            r_ovf_err <= 1'b0;
            r_unf_err <= 1'b0;
        end else if (bus.clear) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_occ     <= '0;
            r_lck_err <= 1'b0;
            r_ovf_err <= 1'b0;
            r_unf_err <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(w_wcnt);
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + AW'(w_rcnt);
            if (w_rd_ok && w_ahb_rd)  r_rx_data <= w_rd_word;
            if (w_rd_ok && !w_ahb_rd) r_tx_data <= r_mem[r_rd_ptr];
            r_occ     <= w_occ_next;
            r_lck_err <= w_lck;
            r_ovf_err <= w_ovf;
            r_unf_err <= w_unf;
        end
    end

    assign bus.rx_data          = r_rx_data;
    assign bus.tx_packet_data   = r_tx_data;
    assign bus.buffer_occupancy = r_occ;
    assign bus.lock_error       = r_lck_err;
    assign bus.overflow_error   = r_ovf_err;
    assign bus.underflow_error  = r_unf_err;

`ifdef DB_WATERMARK_EN
    logic [OW-1:0] r_peak;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_peak <= '0;
        end else if (bus.clear) begin
            r_peak <= '0;
        end else if (w_occ_next > r_peak) begin
            r_peak <= w_occ_next;
        end
    end

    assign bus.peak_occupancy = r_peak;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_data_buffer.sv
`default_nettype none
// ============================================================================
// tb_param_data_buffer
// Directed scenarios plus random traffic against a byte-queue reference model.
// Revision: 1.0
// ============================================================================
module tb_param_data_buffer;
    localparam int DEPTH = 64;
    localparam int DB    = 4;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    param_data_buffer_if #(.DEPTH(DEPTH), .DATA_BYTES(DB)) bus ();

    param_data_buffer #(.DEPTH(DEPTH), .DATA_BYTES(DB)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the buffer is simply a FIFO of bytes
    logic [7:0]  m_q[$];
    logic [31:0] m_rx;
    logic [7:0]  m_tx;
    logic        m_ovf, m_unf, m_lck;
    logic        m_prev_lock;
    int          m_peak;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rx = '0; m_tx = '0;
        m_ovf = 1'b0; m_unf = 1'b0; m_lck = 1'b0;
        m_prev_lock = 1'b0;
        m_peak = 0;
    endtask

    task automatic model_step();
        int occ, n, w, r;
        logic blocked, ahbw, ahbr, wr_ok;
        m_ovf = 1'b0; m_unf = 1'b0; m_lck = 1'b0;
        if (bus.clear) begin
            m_q.delete();
            m_peak = 0;
        end else begin
            blocked = bus.lock_db || m_prev_lock;
            m_lck   = blocked && (bus.store_tx_data || bus.get_rx_data);
            ahbw    = bus.store_tx_data && !blocked;
            ahbr    = bus.get_rx_data && !blocked;
            n = int'(bus.data_size) + 1;
            if (n > DB) n = DB;
            occ = m_q.size();
            w = ahbw ? n : (bus.store_rx_packet_data ? 1 : 0);
            r = ahbr ? n : (bus.get_tx_packet_data ? 1 : 0);
            if (ahbw && bus.store_rx_packet_data) m_ovf = 1'b1;
            if (ahbr && bus.get_tx_packet_data)   m_unf = 1'b1;
            wr_ok = (w > 0) && (occ + w <= DEPTH);
            if (w > 0 && !wr_ok) m_ovf = 1'b1;
            if (r > 0) begin
                if (occ >= r) begin
                    if (ahbr) begin
                        m_rx = '0;
                        for (int k = 0; k < r; k++) m_rx[8*k +: 8] = m_q.pop_front();
                    end else begin
                        m_tx = m_q.pop_front();
                    end
                end else begin
                    m_unf = 1'b1;
                end
            end
            if (wr_ok) begin
                for (int k = 0; k < w; k++)
                    m_q.push_back(ahbw ? bus.tx_data[8*k +: 8] : bus.rx_packet_data);
            end
            if (m_q.size() > m_peak) m_peak = m_q.size();
        end
        m_prev_lock = bus.lock_db;
    endtask

    task automatic check_all();
        check_val("occ", 32'(bus.buffer_occupancy), 32'(m_q.size()));
        check_val("rx_data", bus.rx_data, m_rx);
        check_val("tx_byte", 32'(bus.tx_packet_data), 32'(m_tx));
        check_val("ovf", 32'(bus.overflow_error), 32'(m_ovf));
        check_val("unf", 32'(bus.underflow_error), 32'(m_unf));
        check_val("lck", 32'(bus.lock_error), 32'(m_lck));
`ifdef DB_WATERMARK_EN
        check_val("peak", 32'(bus.peak_occupancy), 32'(m_peak));
`endif
    endtask

    task automatic idle_in();
        bus.clear = 1'b0; bus.lock_db = 1'b0;
        bus.store_tx_data = 1'b0; bus.tx_data = '0; bus.data_size = 2'd0;
        bus.get_rx_data = 1'b0;
        bus.store_rx_packet_data = 1'b0; bus.rx_packet_data = '0;
        bus.get_tx_packet_data = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic ahb_store(input logic [31:0] d, input logic [1:0] ds);
        idle_in();
        bus.store_tx_data = 1'b1; bus.tx_data = d; bus.data_size = ds;
        cycle();
    endtask

    task automatic tx_pop();
        idle_in();
        bus.get_tx_packet_data = 1'b1;
        cycle();
    endtask

    logic [7:0] t2_exp [4];
    logic [7:0] tail [8];

    initial begin
        idle_in();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        cycle();

        // 1: async reset in the middle of traffic
        ahb_store(32'h04030201, 2'd3);
        idle_in(); bus.store_rx_packet_data = 1'b1; bus.rx_packet_data = 8'h55;
        bus.get_tx_packet_data = 1'b1;
        cycle();
        idle_in(); bus.get_rx_data = 1'b1; bus.data_size = 2'd3; bus.store_rx_packet_data = 1'b1;
        cycle();
        n_rst = 1'b0;
        #2;
        check_val("rst_occ", 32'(bus.buffer_occupancy), 32'd0);
        check_val("rst_rx", bus.rx_data, 32'd0);
        check_val("rst_tx", 32'(bus.tx_packet_data), 32'd0);
        check_val("rst_err", {29'd0, bus.lock_error, bus.overflow_error, bus.underflow_error}, 32'd0);
        idle_in();
        @(negedge clk);
        n_rst = 1'b1;
        model_reset();
        repeat (3) cycle();

        // 2: one word in, four bytes out via TX
        t2_exp[0] = 8'hAA; t2_exp[1] = 8'hBB; t2_exp[2] = 8'hCC; t2_exp[3] = 8'hDD;
        ahb_store(32'hDDCCBBAA, 2'd3);
        check_val("t2_occ", 32'(bus.buffer_occupancy), 32'd4);
        for (int i = 0; i < 4; i++) begin
            tx_pop();
            check_val("t2_tx", 32'(bus.tx_packet_data), 32'(t2_exp[i]));
            check_val("t2_occ", 32'(bus.buffer_occupancy), 32'(3 - i));
        end

        // 3: RX bytes, partial AHB read, then an underflowing read
        for (int i = 0; i < 5; i++) begin
            idle_in(); bus.store_rx_packet_data = 1'b1; bus.rx_packet_data = 8'(8'h11 + i);
            cycle();
        end
        idle_in(); bus.get_rx_data = 1'b1; bus.data_size = 2'd1;
        cycle();
        check_val("t3_rx", bus.rx_data, 32'h00001211);
        check_val("t3_occ", 32'(bus.buffer_occupancy), 32'd3);
        idle_in(); bus.get_rx_data = 1'b1; bus.data_size = 2'd3;
        cycle();
        check_val("t3_unf", 32'(bus.underflow_error), 32'd1);
        check_val("t3_occ2", 32'(bus.buffer_occupancy), 32'd3);
        check_val("t3_rx2", bus.rx_data, 32'h00001211);
        idle_in(); cycle();
        check_val("t3_unf_pulse", 32'(bus.underflow_error), 32'd0);
        repeat (3) tx_pop();

        // 4: fill, overflow, wrap and drain
        for (int i = 0; i < 16; i++) ahb_store(32'h03020100 + 32'h04040404 * i, 2'd3);
        check_val("t4_full", 32'(bus.buffer_occupancy), 32'd64);
        ahb_store(32'hDEADBEEF, 2'd3);
        check_val("t4_ovf", 32'(bus.overflow_error), 32'd1);
        check_val("t4_full2", 32'(bus.buffer_occupancy), 32'd64);
        repeat (2) begin
            idle_in(); bus.get_rx_data = 1'b1; bus.data_size = 2'd3;
            cycle();
        end
        ahb_store(32'hA3A2A1A0, 2'd3);
        ahb_store(32'hA7A6A5A4, 2'd3);
        check_val("t4_wrap_occ", 32'(bus.buffer_occupancy), 32'd64);
        for (int i = 0; i < 64; i++) begin
            tx_pop();
            if (i >= 56) tail[i-56] = bus.tx_packet_data;
        end
        for (int i = 0; i < 8; i++) check_val("t4_tail", 32'(tail[i]), 32'(8'hA0 + i));
        check_val("t4_empty", 32'(bus.buffer_occupancy), 32'd0);

        // 5: lockout of AHB side, TX still served
        ahb_store(32'h44332211, 2'd3);
        idle_in(); bus.lock_db = 1'b1; bus.get_rx_data = 1'b1; bus.data_size = 2'd3;
        cycle();
        check_val("t5_lck_rd", 32'(bus.lock_error), 32'd1);
        check_val("t5_occ", 32'(bus.buffer_occupancy), 32'd4);
        idle_in(); bus.lock_db = 1'b1; bus.store_tx_data = 1'b1; bus.tx_data = 32'h99999999;
        bus.data_size = 2'd3;
        cycle();
        check_val("t5_lck_wr", 32'(bus.lock_error), 32'd1);
        check_val("t5_occ2", 32'(bus.buffer_occupancy), 32'd4);
        idle_in(); bus.lock_db = 1'b1; bus.get_tx_packet_data = 1'b1;
        cycle();
        check_val("t5_tx", 32'(bus.tx_packet_data), 32'h11);
        check_val("t5_occ3", 32'(bus.buffer_occupancy), 32'd3);
        check_val("t5_no_lck", 32'(bus.lock_error), 32'd0);
        idle_in(); repeat (2) cycle();
        repeat (3) tx_pop();

        // 6: clear wins over a same-cycle store
        ahb_store(32'h01010101, 2'd3);
        ahb_store(32'h02020202, 2'd3);
        ahb_store(32'h03030303, 2'd1);
        check_val("t6_occ", 32'(bus.buffer_occupancy), 32'd10);
`ifdef DB_WATERMARK_EN
        check_val("t6_peak", 32'(bus.peak_occupancy), 32'd10);
`endif
        idle_in(); bus.clear = 1'b1; bus.store_tx_data = 1'b1; bus.tx_data = 32'h12345678;
        bus.data_size = 2'd3;
        cycle();
        check_val("t6_clr_occ", 32'(bus.buffer_occupancy), 32'd0);
        check_val("t6_clr_err", {29'd0, bus.lock_error, bus.overflow_error, bus.underflow_error}, 32'd0);
`ifdef DB_WATERMARK_EN
        check_val("t6_clr_peak", 32'(bus.peak_occupancy), 32'd0);
`endif

        // Random traffic against the model
        idle_in();
        for (int i = 0; i < 4000; i++) begin
            bus.clear                = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 29) == 0) bus.lock_db = ~bus.lock_db;
            bus.store_tx_data        = ($urandom_range(0, 3) == 0);
            bus.tx_data              = $urandom;
            bus.data_size            = 2'($urandom_range(0, 3));
            bus.get_rx_data          = ($urandom_range(0, 3) == 0);
            bus.store_rx_packet_data = ($urandom_range(0, 2) == 0);
            bus.rx_packet_data       = 8'($urandom);
            bus.get_tx_packet_data   = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
